// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Instruction-fetch controller for the IF stage. It issues one instruction
//   memory read at a time, delivers the returned word to the D stage together
//   with its PC and PC+4, and handles stalls and redirects. A redirect that
//   arrives while a read is in flight is turned into a kill of that read.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//     When it is defined, a FETCH that waits 255 consecutive cycles without an
//     imem_ack moves the controller into a sticky ERR state, which only reset
//     leaves. When it is undefined, FETCH waits indefinitely and fetch_err
//     is tied to 0.
//
// Ports
//   clk             single clock; all state updates on its rising edge
//   reset           synchronous, active-high
//   stall           D stage cannot accept the delivered instruction
//   redirect_valid  taken branch/jump resolved this cycle
//   redirect_pc     redirect target; bits [1:0] are ignored
//   imem_req        instruction memory read request (asserted only in FETCH)
//   imem_addr       word-aligned fetch address
//   imem_ack        read data valid this cycle; ignored outside FETCH
//   imem_rdata      instruction word; sampled only when imem_ack is high
//   if_valid        if_instr/if_pc/if_pc4 hold a deliverable instruction
//   if_instr        delivered instruction
//   if_pc           address of if_instr
//   if_pc4          if_pc + 4
//   fetch_err       sticky fetch timeout flag
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    ERR     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;     // newest redirect target seen while killing
  logic        kill_q, kill_d;     // in-flight read must be discarded on ack
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;

  logic [31:0] redir_tgt;
  logic        tmo_expire;

  // Targets are always forced to a word boundary.
  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       fetch_err_q, fetch_err_d;

  // Counts consecutive ack-less FETCH cycles; anything else clears it.
  // The 255th such cycle is the one whose edge moves the FSM into ERR.
  assign tmo_d      = (state_q == FETCH && !imem_ack) ? tmo_q + 8'd1 : '0;
  assign tmo_expire = (state_q == FETCH) && !imem_ack && (tmo_q == 8'd254);
  assign fetch_err_d = fetch_err_q | tmo_expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign tmo_expire = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
        kill_d  = 1'b0;
      end

      FETCH: begin
        if (tmo_expire) begin
          state_d    = ERR;
          kill_d     = 1'b0;
          if_valid_d = 1'b0;
        end else if (imem_ack) begin
          if (kill_q || redirect_valid) begin
            // Returned word belongs to a squashed path: drop it and refetch
            // from the newest target, a same-cycle redirect beating the
            // latched one.
            pc_d   = redirect_valid ? redir_tgt : pend_q;
            kill_d = 1'b0;
          end else begin
            state_d    = DELIVER;
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + 32'd4;
            pc_d       = pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          // The read already issued cannot be cancelled, so imem_addr keeps
          // pc_q until the ack and the target waits in pend_q.
          kill_d = 1'b1;
          pend_d = redir_tgt;
        end
      end

      DELIVER: begin
        if (redirect_valid) begin
          state_d    = FETCH;
          if_valid_d = 1'b0;
          pc_d       = redir_tgt;
        end else if (!stall) begin
          state_d    = FETCH;
          if_valid_d = 1'b0;
        end
      end

      ERR: begin
        state_d    = ERR;
        if_valid_d = 1'b0;
        kill_d     = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    imem_req  = (state_q == FETCH);
    imem_addr = pc_q;
    if_valid  = if_valid_q;
    if_instr  = if_instr_q;
    if_pc     = if_pc_q;
    if_pc4    = if_pc4_q;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fetch_err;

  int unsigned n_cmp;
  int unsigned n_bad;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_deliver(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check_eq({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
    check_eq({tag, ".instr"}, if_instr, instr);
    check_eq({tag, ".pc"},    if_pc,    pc);
    check_eq({tag, ".pc4"},   if_pc4,   pc + 32'd4);
    check_eq({tag, ".req"},   {31'd0, imem_req}, 32'd0);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr);
    check_eq({tag, ".req"},   {31'd0, imem_req}, 32'd1);
    check_eq({tag, ".addr"},  imem_addr, addr);
    check_eq({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    tick(); tick();
    check_eq("rst.valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst.instr", if_instr, 32'd0);
    check_eq("rst.pc",    if_pc,    32'd0);
    check_eq("rst.pc4",   if_pc4,   32'd0);
    check_eq("rst.err",   {31'd0, fetch_err}, 32'd0);
    check_eq("rst.req",   {31'd0, imem_req},  32'd0);
    reset = 1'b0;

    // Sequential fetch with immediate acks.
    tick();                                   // IDLE -> FETCH
    chk_fetch("f0", 32'h0000_3000);
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    tick();
    chk_deliver("d0", 32'hA000_0000, 32'h0000_3000);
    imem_rdata = BAD;                         // ack outside FETCH is ignored
    tick();
    chk_fetch("f1", 32'h0000_3004);
    imem_rdata = 32'hA000_0001;
    tick();
    chk_deliver("d1", 32'hA000_0001, 32'h0000_3004);

    // Stall holds delivery for 5 cycles.
    stall = 1'b1; imem_rdata = BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_deliver("stall", 32'hA000_0001, 32'h0000_3004);
    end
    stall = 1'b0;
    tick();
    chk_fetch("f2", 32'h0000_3008);

    // Redirect during an outstanding read, ack 3 cycles later.
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3040;
    tick();
    check_eq("kill.addr0", imem_addr, 32'h0000_3008);
    check_eq("kill.req0",  {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b0;
    tick();
    check_eq("kill.addr1", imem_addr, 32'h0000_3008);
    tick();
    check_eq("kill.addr2", imem_addr, 32'h0000_3008);
    imem_ack = 1'b1; imem_rdata = BAD;
    tick();
    chk_fetch("f3040", 32'h0000_3040);
    imem_rdata = 32'hA000_0002;
    tick();
    chk_deliver("d3040", 32'hA000_0002, 32'h0000_3040);
    imem_rdata = BAD;
    tick();
    chk_fetch("f3044", 32'h0000_3044);

    // Redirect coincident with ack, with stall also high.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100; stall = 1'b1;
    tick();
    chk_fetch("f3100", 32'h0000_3100);
    redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'hA000_0003;
    tick();
    chk_deliver("d3100", 32'hA000_0003, 32'h0000_3100);

    // Redirect in DELIVER overrides stall; low target bits dropped.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3103;
    tick();
    chk_fetch("redir_mask", 32'h0000_3100);
    stall = 1'b0;

    // Two redirects before the ack: newest one wins.
    imem_ack = 1'b0; redirect_pc = 32'h0000_5000;
    tick();
    check_eq("multi.addr0", imem_addr, 32'h0000_3100);
    redirect_pc = 32'h0000_6002;
    tick();
    check_eq("multi.addr1", imem_addr, 32'h0000_3100);
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = BAD;
    tick();
    chk_fetch("f6000", 32'h0000_6000);
    imem_rdata = 32'hA000_0004;
    tick();
    chk_deliver("d6000", 32'hA000_0004, 32'h0000_6000);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk_fetch("ftop", 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_rdata = 32'hA000_0005;
    tick();
    check_eq("wrap.pc",  if_pc,  32'hFFFF_FFFC);
    check_eq("wrap.pc4", if_pc4, 32'h0000_0000);
    tick();
    chk_fetch("fwrap", 32'h0000_0000);

    // Reset mid-fetch drops the request; a late ack is ignored.
    reset = 1'b1; imem_ack = 1'b0;
    tick();
    check_eq("rmid.req",   {31'd0, imem_req}, 32'd0);
    check_eq("rmid.valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = BAD;
    tick();
    chk_fetch("rmid.f", 32'h0000_3000);
    imem_ack = 1'b0;

    // Ack withheld: 254 more FETCH cycles still waiting, the next edge
    // completes 255 ack-less cycles.
    for (int i = 0; i < 254; i++) tick();
    check_eq("tmo.req254", {31'd0, imem_req},  32'd1);
    check_eq("tmo.err254", {31'd0, fetch_err}, 32'd0);
    tick();
`ifdef FETCH_TIMEOUT_EN
    check_eq("tmo.err",   {31'd0, fetch_err}, 32'd1);
    check_eq("tmo.req",   {31'd0, imem_req},  32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_7000; imem_ack = 1'b1;
    tick(); tick(); tick();
    check_eq("err.sticky", {31'd0, fetch_err}, 32'd1);
    check_eq("err.req",    {31'd0, imem_req},  32'd0);
    check_eq("err.valid",  {31'd0, if_valid},  32'd0);
    redirect_valid = 1'b0; imem_ack = 1'b0;
`else
    check_eq("tmo.err",  {31'd0, fetch_err}, 32'd0);
    check_eq("tmo.req",  {31'd0, imem_req},  32'd1);
    check_eq("tmo.addr", imem_addr, 32'h0000_3000);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("fin.err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk_fetch("fin.f", 32'h0000_3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
